// File: rtl/game_tick_ctrl_if.sv
// Control/status bundle between the Dino game front end and game_tick_ctrl.
// master drives the player/collision levels; slave returns state, tick, score and level.
interface game_tick_ctrl_if #(
  parameter int SCORE_W = 24
);
  logic               start;
  logic               pause;
  logic               collision;
  logic [1:0]         state;
  logic               running;
  logic               tick;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] hiscore;
  logic [2:0]         level;

  modport master (
    output start, pause, collision,
    input  state, running, tick, score, hiscore, level
  );

  modport slave (
    input  start, pause, collision,
    output state, running, tick, score, hiscore, level
  );
endinterface

// File: rtl/game_tick_ctrl.sv
// Dino game run/pause/over FSM with a level-scaled rate divider; outputs registered (tick is one cycle), no backpressure.
// Define GAME_TICK_BCD_SCORE_EN to count the score in packed BCD instead of binary.
module game_tick_ctrl #(
  parameter int CLK_DIV    = 50_000_000,
  parameter int DIV_DEC    = 5_000_000,
  parameter int DIV_W      = 28,
  parameter int SCORE_W    = 24,
  parameter int LEVEL_STEP = 16,
  parameter int MAX_LEVEL  = 7
) (
  input  logic            clk,
  input  logic            reset,
  game_tick_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam int STEP_W = $clog2(LEVEL_STEP + 1);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] hiscore_q, hiscore_d;
  logic [2:0]         level_q, level_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               tick_q, tick_d;
  logic               start_q, pause_q;
  logic               start_p, pause_p;

  assign start_p = bus.start & ~start_q;
  assign pause_p = bus.pause & ~pause_q;

  function automatic logic [DIV_W-1:0] reload(input logic [2:0] lv);
    return DIV_W'(CLK_DIV - 1) - DIV_W'(DIV_DEC) * DIV_W'(lv);
  endfunction

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
`ifdef GAME_TICK_BCD_SCORE_EN
    logic [SCORE_W-1:0] r;
    logic               c;
    r = s;
    c = 1'b1;
    for (int i = 0; i < SCORE_W / 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    // A carry out of the top digit means every digit was 9: hold at all-9s.
    return c ? s : r;
`else
    return (&s) ? s : s + SCORE_W'(1);
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    score_d   = score_q;
    hiscore_d = hiscore_q;
    level_d   = level_q;
    step_d    = step_q;
    tick_d    = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (start_p) begin
          state_d = RUN;
          score_d = '0;
          level_d = '0;
          step_d  = '0;
          div_d   = reload(3'd0);
        end
      end
      RUN: begin
        if (bus.collision) begin
          state_d = OVER;
          if (score_q > hiscore_q) hiscore_d = score_q;
        end else if (pause_p) begin
          state_d = PAUSE;
        end else if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          tick_d  = 1'b1;
          score_d = score_inc(score_q);
          if (step_q == STEP_W'(LEVEL_STEP - 1)) begin
            step_d = '0;
            if (level_q < 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
          // Reload from the post-increment level so a speed-up takes effect at once.
          div_d = reload(level_d);
        end
      end
      PAUSE: begin
        if (pause_p) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= DIV_W'(CLK_DIV - 1);
      score_q   <= '0;
      hiscore_q <= '0;
      level_q   <= '0;
      step_q    <= '0;
      tick_q    <= 1'b0;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      score_q   <= score_d;
      hiscore_q <= hiscore_d;
      level_q   <= level_d;
      step_q    <= step_d;
      tick_q    <= tick_d;
      start_q   <= bus.start;
      pause_q   <= bus.pause;
    end
  end

  assign bus.state   = state_q;
  assign bus.running = (state_q == RUN);
  assign bus.tick    = tick_q;
  assign bus.score   = score_q;
  assign bus.hiscore = hiscore_q;
  assign bus.level   = level_q;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Directed plus randomized bench for game_tick_ctrl against a tick-count reference model.
// The model tracks ticks and elapsed run cycles; score and level are derived arithmetically.
module tb_game_tick_ctrl;

  localparam int CLK_DIV    = 4;
  localparam int DIV_DEC    = 1;
  localparam int LEVEL_STEP = 2;
  localparam int MAX_LEVEL  = 2;
  localparam int SCORE_W    = 8;

`ifdef GAME_TICK_BCD_SCORE_EN
  localparam int         SAT_T = 99;
  localparam logic [7:0] SAT_V = 8'h99;
  localparam logic [7:0] TEN_V = 8'h10;
`else
  localparam int         SAT_T = 255;
  localparam logic [7:0] SAT_V = 8'hFF;
  localparam logic [7:0] TEN_V = 8'h0A;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  game_tick_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

  game_tick_ctrl #(
    .CLK_DIV(CLK_DIV), .DIV_DEC(DIV_DEC), .DIV_W(8), .SCORE_W(SCORE_W),
    .LEVEL_STEP(LEVEL_STEP), .MAX_LEVEL(MAX_LEVEL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: 0 IDLE, 1 RUN, 2 PAUSE, 3 OVER.
  int         m_state;
  int         m_ticks;
  int         m_elapsed;
  logic [7:0] m_best;
  bit         m_tick;
  bit         m_sq, m_pq;

  function automatic logic [7:0] enc(input int t);
`ifdef GAME_TICK_BCD_SCORE_EN
    int v = (t > 99) ? 99 : t;
    return 8'((v / 10) * 16 + (v % 10));
`else
    return (t > 255) ? 8'hFF : 8'(t);
`endif
  endfunction

  function automatic int m_level();
    int l = m_ticks / LEVEL_STEP;
    return (l > MAX_LEVEL) ? MAX_LEVEL : l;
  endfunction

  function automatic int exp_period(input int k);
    int l = (k - 1) / LEVEL_STEP;
    if (l > MAX_LEVEL) l = MAX_LEVEL;
    return CLK_DIV - l * DIV_DEC;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ticks = 0; m_elapsed = 0; m_best = 8'h00;
    m_tick = 0; m_sq = 0; m_pq = 0;
  endtask

  task automatic model_step(input bit st, input bit pa, input bit co);
    bit sp, pp;
    sp = st & ~m_sq;
    pp = pa & ~m_pq;
    m_sq = st;
    m_pq = pa;
    m_tick = 0;
    case (m_state)
      0, 3: if (sp) begin m_state = 1; m_ticks = 0; m_elapsed = 0; end
      1: begin
        if (co) begin
          m_state = 3;
          if (enc(m_ticks) > m_best) m_best = enc(m_ticks);
        end else if (pp) begin
          m_state = 2;
        end else begin
          m_elapsed++;
          if (m_elapsed == CLK_DIV - m_level() * DIV_DEC) begin
            m_tick = 1;
            m_ticks++;
            m_elapsed = 0;
          end
        end
      end
      2: if (pp) m_state = 1;
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("state",   32'(bus.state),   32'(m_state));
    check("running", 32'(bus.running), 32'(m_state == 1));
    check("tick",    32'(bus.tick),    32'(m_tick));
    check("score",   32'(bus.score),   32'(enc(m_ticks)));
    check("hiscore", 32'(bus.hiscore), 32'(m_best));
    check("level",   32'(bus.level),   32'(m_level()));
  endtask

  task automatic cycle(input bit st, input bit pa, input bit co);
    bus.start = st; bus.pause = pa; bus.collision = co;
    model_step(st, pa, co);
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 0; bus.pause = 0; bus.collision = 0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    check_outputs();
  endtask

  task automatic wait_tick(input int exp);
    int n;
    n = 0;
    do begin
      cycle(0, 0, 0);
      n++;
    end while (!bus.tick && n < exp + 8);
    check("tick_latency", 32'(n), 32'(exp));
  endtask

  initial begin
    bus.start = 0; bus.pause = 0; bus.collision = 0;
    model_reset();

    // Reset values
    do_reset();
    do_reset();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_score", 32'(bus.score), 32'd0);

    // Start, first ticks, pause at divider=2 on level 1
    cycle(1, 0, 0);
    check("start_state", 32'(bus.state), 32'd1);
    wait_tick(4);
    check("score_1", 32'(bus.score), 32'd1);
    wait_tick(4);
    check("level_1", 32'(bus.level), 32'd1);
    cycle(0, 1, 0);
    check("pause_state", 32'(bus.state), 32'd2);
    for (int i = 0; i < 20; i++) cycle(i == 7, i < 5, (i % 3) == 0);
    check("pause_score", 32'(bus.score), 32'd2);
    cycle(0, 1, 0);
    check("resume_state", 32'(bus.state), 32'd1);
    wait_tick(3);
    wait_tick(3);
    check("level_2", 32'(bus.level), 32'd2);
    wait_tick(2);
    check("score_5", 32'(bus.score), 32'd5);
    cycle(0, 0, 1);
    check("over_state", 32'(bus.state), 32'd3);
    check("hiscore_5", 32'(bus.hiscore), 32'd5);

    // Restart, lower score does not replace hiscore
    cycle(1, 0, 0);
    check("restart_score", 32'(bus.score), 32'd0);
    for (int k = 1; k <= 3; k++) wait_tick(exp_period(k));
    cycle(0, 0, 1);
    check("hiscore_kept", 32'(bus.hiscore), 32'd5);
    check("score_held", 32'(bus.score), 32'd3);

    // Collision in the same cycle as divider==0
    cycle(1, 0, 0);
    wait_tick(4);
    wait_tick(4);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    check("col_div0_state", 32'(bus.state), 32'd3);
    check("col_div0_tick", 32'(bus.tick), 32'd0);
    check("col_div0_score", 32'(bus.score), 32'd2);
    cycle(0, 0, 0);
    check("col_div0_tick2", 32'(bus.tick), 32'd0);

    // Long run: level saturation, decimal/binary rollover, score saturation
    cycle(1, 0, 0);
    for (int k = 1; k <= SAT_T + 2; k++) begin
      wait_tick(exp_period(k));
      if (k == 6) begin
        check("level_sat", 32'(bus.level), 32'd2);
        check("score_6", 32'(bus.score), 32'd6);
      end
      if (k == 9)  check("score_9", 32'(bus.score), 32'h09);
      if (k == 10) check("score_10", 32'(bus.score), 32'(TEN_V));
    end
    check("score_sat", 32'(bus.score), 32'(SAT_V));
    check("sat_tick", 32'(bus.tick), 32'd1);

    // Reset mid-run clears everything including hiscore
    cycle(0, 0, 0);
    do_reset();
    check("mid_rst_state", 32'(bus.state), 32'd0);
    check("mid_rst_hiscore", 32'(bus.hiscore), 32'd0);
    check("mid_rst_level", 32'(bus.level), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 39) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
